approx_mult_pipe: RTL and testbench

- Pipelined, parametrised unsigned multiplier built from 4x4 tiles.
- Each transaction selects either an exact product or an approximate product. In approximate mode, low-order tiles drop carries in their low columns.
- Sits between operand producers and accumulators in the approximate-arithmetic datapath.
- Valid/ready handshake on both sides with full-pipeline stall on backpressure.

---
 rtl/approx_mult_pkg.sv | 9 +
 rtl/approx_mult_pipe_tile.sv | 20 ++
 rtl/approx_mult_pipe.sv | 104 ++++++++++
 tb/tb_approx_mult_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared constants and tile-selection helper for the approximate multiplier
package approx_mult_pkg;
    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;
    localparam int   CNT_W       = 16;
    function automatic logic tile_is_approx(input int i, input int j, input int level);
        return (i + j) < level;
    endfunction
endpackage

// File: rtl/approx_mult_pipe_tile.sv
// approx_tile_4x4: 4x4 unsigned tile, exact or with OR-compressed low columns
module approx_tile_4x4 #(
    parameter int CUT = 4
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       approx_en,
    output logic [7:0] p
);
    logic [7:0] lo, hi;
    always_comb begin
        lo = '0;
        hi = '0;
        for (int u = 0; u < 4; u++)
            for (int v = 0; v < 4; v++)
                if (u + v < CUT) lo[u+v] = lo[u+v] | (a[u] & b[v]);
                else hi = hi + (8'(a[u] & b[v]) << (u + v));
        p = approx_en ? (lo | hi) : {4'b0, a} * {4'b0, b};
    end
endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage tiled multiplier (operands, tile products, sum) with global stall
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CUT          = 4,
    parameter int APPROX_LEVEL = 1,
    parameter int TAG_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   approx_cnt
);
    localparam int N  = WIDTH / 4;
    localparam int PW = 2 * WIDTH;

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
        $error("approx_mult_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    logic               en;
    logic               v1_q, m1_q, v2_q, m2_q, v3_q, m3_q;
    logic [WIDTH-1:0]   a1_q, b1_q;
    logic [TAG_W-1:0]   t1_q, t2_q, t3_q;
    logic [N*N-1:0][7:0] tp_d, tp_q;
    logic [PW-1:0]      p_d, p_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               inc;

    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < N; i++) begin : g_a
        for (genvar j = 0; j < N; j++) begin : g_b
            approx_tile_4x4 #(.CUT(CUT)) u_tile (
                .a        (a1_q[4*i +: 4]),
                .b        (b1_q[4*j +: 4]),
                .approx_en(m1_q == MODE_APPROX && tile_is_approx(i, j, APPROX_LEVEL)),
                .p        (tp_d[i*N+j])
            );
        end
    end

    always_comb begin
        p_d = '0;
        for (int k = 0; k < N * N; k++)
            p_d = p_d + (PW'(tp_q[k]) << (4 * (k / N + k % N)));
    end

    // Counts deliveries of approximate results; holds at all-ones
    assign inc   = v3_q && out_ready && m3_q == MODE_APPROX && cnt_q != '1;
    assign cnt_d = cnt_q + CNT_W'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            m1_q  <= 1'b0;
            t1_q  <= '0;
            v2_q  <= 1'b0;
            tp_q  <= '0;
            m2_q  <= 1'b0;
            t2_q  <= '0;
            v3_q  <= 1'b0;
            p_q   <= '0;
            m3_q  <= 1'b0;
            t3_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (en) begin
                v1_q <= in_valid;
                a1_q <= in_a;
                b1_q <= in_b;
                m1_q <= in_mode;
                t1_q <= in_tag;
                v2_q <= v1_q;
                tp_q <= tp_d;
                m2_q <= m1_q;
                t2_q <= t1_q;
                v3_q <= v2_q;
                p_q  <= p_d;
                m3_q <= m2_q;
                t3_q <= t2_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = v3_q;
    assign out_p      = p_q;
    assign out_tag    = t3_q;
    assign approx_cnt = cnt_q;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed and randomized checks against a tile-level arithmetic model
module tb_approx_mult_pipe;
    localparam int WIDTH = 8, CUT = 4, LEVEL = 1, TAG_W = 4;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  tag;
        logic        mode;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_mode = 0, out_valid, out_ready = 0;
    logic [7:0]  in_a = 0, in_b = 0;
    logic [3:0]  in_tag = 0, out_tag;
    logic [15:0] out_p, approx_cnt;
    int          n_cmp = 0, n_err = 0;

    approx_mult_pipe #(.WIDTH(WIDTH), .CUT(CUT), .APPROX_LEVEL(LEVEL), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag), .approx_cnt(approx_cnt)
    );

    always #5 clk = ~clk;

    // Approximate tile = true product with the low-column contributions replaced by their OR
    function automatic int ref_tile(input int x, input int y, input bit apx);
        int lo, rest;
        rest = x * y;
        lo = 0;
        if (apx)
            for (int u = 0; u < 4; u++)
                for (int v = 0; v < 4; v++)
                    if (u + v < CUT && ((x >> u) & 1) == 1 && ((y >> v) & 1) == 1) begin
                        rest -= 1 << (u + v);
                        lo |= 1 << (u + v);
                    end
        return rest + lo;
    endfunction

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b, input bit m);
        int s = 0;
        for (int i = 0; i < WIDTH / 4; i++)
            for (int j = 0; j < WIDTH / 4; j++)
                s += ref_tile((a >> (4 * i)) & 15, (b >> (4 * j)) & 15, m && (i + j < LEVEL)) << (4 * (i + j));
        return 16'(s);
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m, input logic [3:0] t);
        in_valid = v; in_a = a; in_b = b; in_mode = m; in_tag = t;
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic m, input logic [3:0] t,
                           output logic [15:0] p, output logic [3:0] tg, output int lat);
        @(negedge clk);
        drive(1, a, b, m, t);
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        p = out_p;
        tg = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_p !== 16'h0) begin n_err++; $display("FAIL reset_p got=%h want=0000", out_p); end
        n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_tag got=%h want=0", out_tag); end
        n_cmp++; if (approx_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", approx_cnt); end
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed;
        logic [15:0] p;
        logic [3:0]  tg;
        int          lat;
        run_one(8'h0F, 8'h0F, 0, 4'd3, p, tg, lat);
        n_cmp++; if (p !== 16'h00E1) begin n_err++; $display("FAIL exact_0f got=%h want=00e1", p); end
        n_cmp++; if (tg !== 4'd3) begin n_err++; $display("FAIL exact_0f_tag got=%0d want=3", tg); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL latency got=%0d want=2", lat); end
        n_cmp++; if (approx_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_exact got=%0d want=0", approx_cnt); end
        run_one(8'h0F, 8'h0F, 1, 4'd4, p, tg, lat);
        n_cmp++; if (p !== 16'h00BF) begin n_err++; $display("FAIL approx_0f got=%h want=00bf", p); end
        n_cmp++; if (approx_cnt !== 16'd1) begin n_err++; $display("FAIL cnt_approx got=%0d want=1", approx_cnt); end
        run_one(8'hFF, 8'hFF, 1, 4'd5, p, tg, lat);
        n_cmp++; if (p !== 16'hFDDF) begin n_err++; $display("FAIL approx_ff got=%h want=fddf", p); end
        run_one(8'hFF, 8'hFF, 0, 4'd6, p, tg, lat);
        n_cmp++; if (p !== 16'hFE01) begin n_err++; $display("FAIL exact_ff got=%h want=fe01", p); end
        n_cmp++; if (approx_cnt !== 16'd2) begin n_err++; $display("FAIL cnt_after_ff got=%0d want=2", approx_cnt); end
    endtask

    task automatic test_back_to_back;
        exp_t e[4];
        int   k = 0;
        out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 4) begin
                e[c].p = 0;
                drive(1, 8'($urandom), 8'($urandom), c[0], 4'(c));
                e[c].p = ref_mult(in_a, in_b, in_mode);
                e[c].tag = in_tag;
            end else in_valid = 0;
            #1;
            n_cmp++;
            if (out_valid !== (c >= 3 && c < 7)) begin n_err++; $display("FAIL b2b_valid c=%0d got=%b", c, out_valid); end
            if (out_valid && k < 4) begin
                n_cmp++;
                if (out_p !== e[k].p || out_tag !== e[k].tag) begin
                    n_err++; $display("FAIL b2b_data k=%0d got=%h/%0d want=%h/%0d", k, out_p, out_tag, e[k].p, e[k].tag);
                end
                k++;
            end
        end
    endtask

    task automatic test_backpressure;
        exp_t e[3];
        int   n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 0;
            drive(1, 8'($urandom), 8'($urandom), 1'($urandom), 4'(8 + c));
            e[c].p = ref_mult(in_a, in_b, in_mode);
            e[c].tag = in_tag;
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            drive(1, 8'hAA, 8'h55, 1, 4'hF);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_stall s=%0d in_ready=%b out_valid=%b", s, in_ready, out_valid);
            end
            n_cmp++;
            if (out_p !== e[0].p || out_tag !== e[0].tag) begin
                n_err++; $display("FAIL bp_hold s=%0d got=%h/%0d want=%h/%0d", s, out_p, out_tag, e[0].p, e[0].tag);
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 0;
            out_ready = 1;
            #1;
            if (out_valid) begin
                n_cmp++;
                if (n >= 3) begin
                    n_err++; $display("FAIL bp_extra got=%h/%0d want=none", out_p, out_tag);
                end else if (out_p !== e[n].p || out_tag !== e[n].tag) begin
                    n_err++; $display("FAIL bp_drain n=%0d got=%h/%0d want=%h/%0d", n, out_p, out_tag, e[n].p, e[n].tag);
                end
                n++;
            end
        end
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL bp_count got=%0d want=3", n); end
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        int   exp_cnt = 0;
        logic [3:0] tag = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive(c < 390 && $urandom_range(3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), tag);
            out_ready = c >= 390 || $urandom_range(2) != 0;
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_unexpected got=%h/%0d want=none", out_p, out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        n_err++; $display("FAIL rand_data got=%h/%0d want=%h/%0d", out_p, out_tag, e.p, e.tag);
                    end
                    if (e.mode) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                e.p = ref_mult(in_a, in_b, in_mode);
                e.tag = in_tag;
                e.mode = in_mode;
                q.push_back(e);
                tag++;
            end
        end
        @(negedge clk);
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
        n_cmp++; if (approx_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL rand_cnt got=%0d want=%0d", approx_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1, 8'h0F, 8'h0F, 1, 4'(c));
        end
        @(negedge clk);
        in_valid = 0;
        #2 rst = 1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        n_cmp++; if (approx_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got=%0d want=0", approx_cnt); end
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ghost c=%0d got=%b want=0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
